// File: rtl/stopwatch_pkg.sv
// Shared state encoding, cycle constants and width helper
// for the stopwatch sequencer.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_PAUSE  = 2'd2,
        ST_ADJUST = 2'd3
    } state_e;

    localparam int SEC_CYCLES_DEF   = 100000000;
    localparam int ADJ_CYCLES_DEF   = 50000000;
    localparam int BLINK_CYCLES_DEF = 25000000;
    localparam int DB_CYCLES_DEF    = 1000000;

    // Short periods so a simulation exercises every wrap quickly
    localparam int SIM_SEC_CYCLES   = 10;
    localparam int SIM_ADJ_CYCLES   = 5;
    localparam int SIM_BLINK_CYCLES = 3;
    localparam int SIM_DB_CYCLES    = 4;

    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser, stability counter and one-cycle
// press pulse for a raw push button.
module btn_debounce
    import stopwatch_pkg::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_i,
    output logic press_o
);

    localparam int CW = cnt_w(DB_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);

    logic          s1_q;
    logic          s2_q;
    logic          lvl_q;
    logic          press_q;
    logic [CW-1:0] cnt_q;

    // Any return to the accepted level restarts the stability count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            lvl_q   <= 1'b0;
            press_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            s1_q    <= btn_i;
            s2_q    <= s1_q;
            press_q <= 1'b0;
            if (s2_q == lvl_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_MAX) begin
                cnt_q   <= '0;
                lvl_q   <= s2_q;
                press_q <= s2_q;
            end else begin
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencer: IDLE/RUN/PAUSE/ADJUST state machine
// emitting registered one-cycle enables and a blink level.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int SEC_CYCLES   = SEC_CYCLES_DEF,
    parameter int ADJ_CYCLES   = ADJ_CYCLES_DEF,
    parameter int BLINK_CYCLES = BLINK_CYCLES_DEF,
    parameter int DB_CYCLES    = DB_CYCLES_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_pause,
    input  logic       btn_reset,
    input  logic       sw_adj,
    input  logic       sw_sel,
    output logic       sec_en,
    output logic       adj_min_en,
    output logic       adj_sec_en,
    output logic       clr,
    output logic       blink,
    output logic [1:0] state
);

    localparam int SW = cnt_w(SEC_CYCLES);
    localparam int AW = cnt_w(ADJ_CYCLES);
    localparam int BW = cnt_w(BLINK_CYCLES);
    localparam logic [SW-1:0] SEC_MAX   = SW'(SEC_CYCLES - 1);
    localparam logic [AW-1:0] ADJ_MAX   = AW'(ADJ_CYCLES - 1);
    localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_CYCLES - 1);

    logic          pause_press;
    logic          reset_press;
    logic          adj_s1_q, adj_s2_q;
    logic          sel_s1_q, sel_s2_q;
    state_e        state_q, state_d;
    logic [SW-1:0] sec_div_q, sec_div_d;
    logic [AW-1:0] adj_div_q, adj_div_d;
    logic [BW-1:0] blink_div_q, blink_div_d;
    logic          blink_q, blink_d;
    logic          sec_en_q, sec_en_d;
    logic          adj_min_q, adj_min_d;
    logic          adj_sec_q, adj_sec_d;
    logic          clr_q, clr_d;
    logic          tick_d;

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_pause (
        .clk     (clk),
        .rst     (rst),
        .btn_i   (btn_pause),
        .press_o (pause_press)
    );

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_reset (
        .clk     (clk),
        .rst     (rst),
        .btn_i   (btn_reset),
        .press_o (reset_press)
    );

    always_comb begin
        state_d   = state_q;
        sec_div_d = sec_div_q;
        if (state_q == ST_RUN) begin
            sec_div_d = (sec_div_q == SEC_MAX) ? '0 : sec_div_q + SW'(1);
        end
        if (reset_press) begin
            state_d   = ST_IDLE;
            sec_div_d = '0;
        end else if (adj_s2_q && state_q != ST_ADJUST) begin
            state_d   = ST_ADJUST;
            sec_div_d = '0;
        end else if (state_q == ST_ADJUST && !adj_s2_q) begin
            state_d = ST_PAUSE;
        end else if (pause_press) begin
            unique case (state_q)
                ST_IDLE, ST_PAUSE: state_d = ST_RUN;
                ST_RUN:            state_d = ST_PAUSE;
                default:           state_d = state_q;
            endcase
        end

        // Adjust/blink dividers sit at zero outside ADJUST, so entry restarts them
        adj_div_d   = '0;
        blink_div_d = '0;
        blink_d     = 1'b0;
        if (state_q == ST_ADJUST) begin
            adj_div_d   = (adj_div_q == ADJ_MAX) ? '0 : adj_div_q + AW'(1);
            blink_div_d = (blink_div_q == BLINK_MAX) ? '0 : blink_div_q + BW'(1);
            blink_d     = (blink_div_q == BLINK_MAX) ? ~blink_q : blink_q;
        end
        if (state_d != ST_ADJUST) begin
            blink_d = 1'b0;
        end

        // Enables are registered against the next divider value
        tick_d    = (state_d == ST_ADJUST) && (adj_div_d == ADJ_MAX);
        sec_en_d  = (state_d == ST_RUN) && (sec_div_d == SEC_MAX);
        adj_min_d = tick_d & ~sel_s2_q;
        adj_sec_d = tick_d & sel_s2_q;
        clr_d     = reset_press;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            adj_s1_q    <= 1'b0;
            adj_s2_q    <= 1'b0;
            sel_s1_q    <= 1'b0;
            sel_s2_q    <= 1'b0;
            state_q     <= ST_IDLE;
            sec_div_q   <= '0;
            adj_div_q   <= '0;
            blink_div_q <= '0;
            blink_q     <= 1'b0;
            sec_en_q    <= 1'b0;
            adj_min_q   <= 1'b0;
            adj_sec_q   <= 1'b0;
            clr_q       <= 1'b0;
        end else begin
            adj_s1_q    <= sw_adj;
            adj_s2_q    <= adj_s1_q;
            sel_s1_q    <= sw_sel;
            sel_s2_q    <= sel_s1_q;
            state_q     <= state_d;
            sec_div_q   <= sec_div_d;
            adj_div_q   <= adj_div_d;
            blink_div_q <= blink_div_d;
            blink_q     <= blink_d;
            sec_en_q    <= sec_en_d;
            adj_min_q   <= adj_min_d;
            adj_sec_q   <= adj_sec_d;
            clr_q       <= clr_d;
        end
    end

    assign sec_en     = sec_en_q;
    assign adj_min_en = adj_min_q;
    assign adj_sec_en = adj_sec_q;
    assign clr        = clr_q;
    assign blink      = blink_q;
    assign state      = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed table-driven bench for stopwatch_ctrl using the
// short simulation periods from the package.
module tb_stopwatch_ctrl;
    import stopwatch_pkg::*;

    typedef struct {
        logic p;
        logic r;
        logic a;
        logic s;
        int   n;
        int   st;
        int   nsec;
        int   nmin;
        int   nasec;
        int   nclr;
        int   blk;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_pause = 1'b0;
    logic       btn_reset = 1'b0;
    logic       sw_adj = 1'b0;
    logic       sw_sel = 1'b0;
    logic       sec_en;
    logic       adj_min_en;
    logic       adj_sec_en;
    logic       clr;
    logic       blink;
    logic [1:0] state;

    int cmp = 0;
    int bad = 0;
    int c_sec, c_min, c_asec, c_clr;
    vec_t vecs[22];

    stopwatch_ctrl #(
        .SEC_CYCLES   (SIM_SEC_CYCLES),
        .ADJ_CYCLES   (SIM_ADJ_CYCLES),
        .BLINK_CYCLES (SIM_BLINK_CYCLES),
        .DB_CYCLES    (SIM_DB_CYCLES)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_pause  (btn_pause),
        .btn_reset  (btn_reset),
        .sw_adj     (sw_adj),
        .sw_sel     (sw_sel),
        .sec_en     (sec_en),
        .adj_min_en (adj_min_en),
        .adj_sec_en (adj_sec_en),
        .clr        (clr),
        .blink      (blink),
        .state      (state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        cmp++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic clr_counts();
        c_sec  = 0;
        c_min  = 0;
        c_asec = 0;
        c_clr  = 0;
    endtask

    task automatic sample();
        @(negedge clk);
        c_sec  += int'(sec_en);
        c_min  += int'(adj_min_en);
        c_asec += int'(adj_sec_en);
        c_clr  += int'(clr);
        chk("enable exclusivity",
            int'($onehot0({sec_en, adj_min_en, adj_sec_en, clr})), 1);
    endtask

    task automatic apply(input int i);
        btn_pause = vecs[i].p;
        btn_reset = vecs[i].r;
        sw_adj    = vecs[i].a;
        sw_sel    = vecs[i].s;
        clr_counts();
        repeat (vecs[i].n) sample();
        chk($sformatf("v%0d state", i), int'(state), vecs[i].st);
        chk($sformatf("v%0d sec_en count", i), c_sec, vecs[i].nsec);
        chk($sformatf("v%0d adj_min count", i), c_min, vecs[i].nmin);
        chk($sformatf("v%0d adj_sec count", i), c_asec, vecs[i].nasec);
        chk($sformatf("v%0d clr count", i), c_clr, vecs[i].nclr);
        chk($sformatf("v%0d blink", i), int'(blink), vecs[i].blk);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        //          p  r  a  s   n  st sec min asec clr blk
        vecs[0]  = '{1, 0, 0, 0,  3, 0, 0, 0, 0, 0, 0};
        vecs[1]  = '{0, 0, 0, 0, 10, 0, 0, 0, 0, 0, 0};
        vecs[2]  = '{1, 0, 0, 0,  7, 1, 0, 0, 0, 0, 0};
        vecs[3]  = '{0, 0, 0, 0, 30, 1, 3, 0, 0, 0, 0};
        vecs[4]  = '{1, 0, 0, 0,  7, 2, 0, 0, 0, 0, 0};
        vecs[5]  = '{0, 0, 0, 0, 10, 2, 0, 0, 0, 0, 0};
        vecs[6]  = '{1, 0, 0, 0,  7, 1, 0, 0, 0, 0, 0};
        vecs[7]  = '{0, 0, 0, 0,  1, 1, 0, 0, 0, 0, 0};
        vecs[8]  = '{0, 0, 0, 0,  1, 1, 1, 0, 0, 0, 0};
        vecs[9]  = '{0, 0, 1, 0,  2, 1, 0, 0, 0, 0, 0};
        vecs[10] = '{0, 0, 1, 1,  5, 3, 0, 0, 1, 0, 0};
        vecs[11] = '{0, 0, 0, 1,  3, 2, 0, 0, 0, 0, 0};
        vecs[12] = '{0, 1, 0, 1,  7, 0, 0, 0, 0, 1, 0};
        vecs[13] = '{0, 0, 0, 1,  8, 0, 0, 0, 0, 0, 0};
        vecs[14] = '{1, 0, 0, 1,  7, 1, 0, 0, 0, 0, 0};
        vecs[15] = '{0, 0, 0, 1,  8, 1, 0, 0, 0, 0, 0};
        vecs[16] = '{0, 0, 0, 1,  1, 1, 1, 0, 0, 0, 0};
        vecs[17] = '{1, 1, 0, 1,  7, 0, 0, 0, 0, 1, 0};
        vecs[18] = '{0, 0, 0, 1,  8, 0, 0, 0, 0, 0, 0};
        vecs[19] = '{1, 0, 0, 1,  7, 1, 0, 0, 0, 0, 0};
        vecs[20] = '{0, 0, 0, 1,  9, 1, 1, 0, 0, 0, 0};
        vecs[21] = '{0, 0, 0, 1,  5, 0, 0, 0, 0, 0, 0};

        repeat (3) @(negedge clk);
        chk("reset state", int'(state), 0);
        chk("reset sec_en", int'(sec_en), 0);
        chk("reset adj_min_en", int'(adj_min_en), 0);
        chk("reset adj_sec_en", int'(adj_sec_en), 0);
        chk("reset clr", int'(clr), 0);
        chk("reset blink", int'(blink), 0);
        rst = 1'b0;

        for (int i = 0; i <= 9; i++) apply(i);

        // ADJUST with sel=0: ticks every 5 cycles, blink every 3
        clr_counts();
        for (int k = 1; k <= 22; k++) begin
            sample();
            chk($sformatf("adj k%0d state", k), int'(state), 3);
            chk($sformatf("adj k%0d blink", k), int'(blink), ((k - 1) / 3) % 2);
            chk($sformatf("adj k%0d adj_min_en", k), int'(adj_min_en),
                (k % 5 == 0) ? 1 : 0);
            chk($sformatf("adj k%0d adj_sec_en", k), int'(adj_sec_en), 0);
        end
        chk("adj adj_min total", c_min, 4);

        for (int i = 10; i <= 20; i++) apply(i);

        chk("pre-rst sec_en", int'(sec_en), 1);
        #2;
        rst = 1'b1;
        #1;
        chk("async rst state", int'(state), 0);
        chk("async rst sec_en", int'(sec_en), 0);
        chk("async rst clr", int'(clr), 0);
        chk("async rst adj", int'(adj_min_en | adj_sec_en), 0);
        chk("async rst blink", int'(blink), 0);
        @(negedge clk);
        rst = 1'b0;

        apply(21);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
        $finish;
    end

endmodule
